// File: rtl/prefix_pkg.sv
// Shared definitions for the grouped Brent-Kung prefix adder/subtractor family.
// Group pairs are encoded as {generate, propagate}.
package prefix_pkg;

  localparam int WIDTH_DEF     = 64;
  localparam int GROUPSIZE_DEF = 8;

  typedef logic [1:0] gp_t;

  function automatic int ngroups(input int width, input int groupsize);
    return width / groupsize;
  endfunction

  // hi covers the more significant span, lo the less significant one
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    return {hi[1] | (hi[0] & lo[1]), hi[0] & lo[0]};
  endfunction

endpackage

// File: rtl/prefix_carry_tree.sv
// Combinational Brent-Kung prefix over NG group (g, p) pairs; c[i] is the carry
// into group i. The carry-in of group 0 must already be folded into gp[0].
module prefix_carry_tree
  import prefix_pkg::*;
#(
  parameter int NG = 8
) (
  input  gp_t [NG-1:0] gp,
  output logic [NG:1]  c
);

  gp_t [NG-1:0] t;

  always_comb begin
    t = gp;
    // up-sweep leaves full prefixes at indices 2^k - 1
    for (int d = 1; d < NG; d = d * 2) begin
      for (int i = 2 * d - 1; i < NG; i = i + 2 * d) begin
        t[i] = gp_combine(t[i], t[i-d]);
      end
    end
    for (int d = NG / 4; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < NG; i = i + 2 * d) begin
        t[i] = gp_combine(t[i], t[i-d]);
      end
    end
    c = '0;
    for (int i = 0; i < NG; i++) begin
      c[i+1] = t[i][1];
    end
  end

endmodule

// File: rtl/prefix_subtractor_pipe.sv
// Three-stage pipelined subtractor (a + ~b + 1) with valid/ready flow control
// and borrow / zero / signed-less-than / overflow flags.
module prefix_subtractor_pipe
  import prefix_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int GROUPSIZE = GROUPSIZE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_zero,
  output logic             out_lt,
  output logic             out_ovf
);

  localparam int NG = ngroups(WIDTH, GROUPSIZE);

  logic             v1, v2, v3;
  logic             adv1, adv2, adv3;
  logic [WIDTH-1:0] nb_in, a1, nb1, a2, nb2, diff_s3;
  gp_t [NG-1:0]     gp_s0, gp1;
  gp_t              bit_gp, acc_gp;
  logic [NG:1]      c_tree;
  logic [NG:0]      c2;
  logic             carry, ovf_s3;

  assign adv3      = ~v3 | out_ready;
  assign adv2      = ~v2 | adv3;
  assign adv1      = ~v1 | adv2;
  assign in_ready  = adv1 & ~rst;
  assign out_valid = v3;
  assign nb_in     = ~in_b;

  always_comb begin
    gp_s0  = '0;
    bit_gp = '0;
    acc_gp = '0;
    for (int i = 0; i < NG; i++) begin
      acc_gp = {in_a[i*GROUPSIZE] & nb_in[i*GROUPSIZE], in_a[i*GROUPSIZE] ^ nb_in[i*GROUPSIZE]};
      for (int j = 1; j < GROUPSIZE; j++) begin
        bit_gp = {in_a[i*GROUPSIZE+j] & nb_in[i*GROUPSIZE+j],
                  in_a[i*GROUPSIZE+j] ^ nb_in[i*GROUPSIZE+j]};
        acc_gp = gp_combine(bit_gp, acc_gp);
      end
      gp_s0[i] = acc_gp;
    end
    // the +1 of the two's-complement negation enters here as group 0's carry-in
    gp_s0[0] = {gp_s0[0][1] | gp_s0[0][0], gp_s0[0][0]};
  end

  prefix_carry_tree #(
    .NG(NG)
  ) u_carry_tree (
    .gp(gp1),
    .c (c_tree)
  );

  always_comb begin
    diff_s3 = '0;
    carry   = 1'b0;
    for (int i = 0; i < NG; i++) begin
      carry = c2[i];
      for (int j = 0; j < GROUPSIZE; j++) begin
        diff_s3[i*GROUPSIZE+j] = a2[i*GROUPSIZE+j] ^ nb2[i*GROUPSIZE+j] ^ carry;
        carry = (a2[i*GROUPSIZE+j] & nb2[i*GROUPSIZE+j]) |
                ((a2[i*GROUPSIZE+j] ^ nb2[i*GROUPSIZE+j]) & carry);
      end
    end
    ovf_s3 = (a2[WIDTH-1] ^ ~nb2[WIDTH-1]) & (a2[WIDTH-1] ^ diff_s3[WIDTH-1]);
  end

  // Data registers only load when a valid entry moves in, so bubbles never
  // overwrite a held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      a1         <= '0;
      nb1        <= '0;
      gp1        <= '0;
      a2         <= '0;
      nb2        <= '0;
      c2         <= '0;
      out_diff   <= '0;
      out_borrow <= 1'b0;
      out_zero   <= 1'b0;
      out_lt     <= 1'b0;
      out_ovf    <= 1'b0;
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        if (in_valid) begin
          a1  <= in_a;
          nb1 <= nb_in;
          gp1 <= gp_s0;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          a2  <= a1;
          nb2 <= nb1;
          c2  <= {c_tree, 1'b1};
        end
      end
      if (adv3) begin
        v3 <= v2;
        if (v2) begin
          out_diff   <= diff_s3;
          out_borrow <= ~c2[NG];
          out_zero   <= (diff_s3 == '0);
          out_ovf    <= ovf_s3;
          out_lt     <= diff_s3[WIDTH-1] ^ ovf_s3;
        end
      end
    end
  end

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Scoreboard bench for prefix_subtractor_pipe; three configurations share one
// stimulus stream and are checked against a behavioural a - b model.
module tb_prefix_subtractor_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;

  logic        in_ready, out_valid, out_borrow, out_zero, out_lt, out_ovf;
  logic [63:0] out_diff;
  logic        rdy_g1, valid_g1, borrow_g1, zero_g1, lt_g1, ovf_g1;
  logic [63:0] diff_g1;
  logic        rdy_32, valid_32, borrow_32, zero_32, lt_32, ovf_32;
  logic [31:0] diff_32;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  logic [127:0] sb[$];

  always #5 clk = ~clk;

  prefix_subtractor_pipe #(.WIDTH(64), .GROUPSIZE(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_borrow(out_borrow), .out_zero(out_zero),
    .out_lt(out_lt), .out_ovf(out_ovf)
  );

  prefix_subtractor_pipe #(.WIDTH(64), .GROUPSIZE(1)) dut_g1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_g1),
    .in_a(in_a), .in_b(in_b), .out_valid(valid_g1), .out_ready(out_ready),
    .out_diff(diff_g1), .out_borrow(borrow_g1), .out_zero(zero_g1),
    .out_lt(lt_g1), .out_ovf(ovf_g1)
  );

  prefix_subtractor_pipe #(.WIDTH(32), .GROUPSIZE(4)) dut_32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_32),
    .in_a(in_a[31:0]), .in_b(in_b[31:0]), .out_valid(valid_32), .out_ready(out_ready),
    .out_diff(diff_32), .out_borrow(borrow_32), .out_zero(zero_32),
    .out_lt(lt_32), .out_ovf(ovf_32)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareResult();
    logic [127:0] p;
    logic [63:0]  a, b, d;
    logic [31:0]  a32, b32, d32;
    logic         e_borrow, e_zero, e_lt, e_ovf;
    checkOutput("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() == 0) return;
    p = sb.pop_front();
    pops++;
    a = p[127:64];
    b = p[63:0];
    d = a - b;
    e_borrow = a < b;
    e_zero   = d == 64'd0;
    e_lt     = $signed(a) < $signed(b);
    e_ovf    = (a[63] != b[63]) && (d[63] != a[63]);
    checkOutput("diff", out_diff, d);
    checkOutput("borrow", 64'(out_borrow), 64'(e_borrow));
    checkOutput("zero", 64'(out_zero), 64'(e_zero));
    checkOutput("lt", 64'(out_lt), 64'(e_lt));
    checkOutput("ovf", 64'(out_ovf), 64'(e_ovf));
    checkOutput("valid_g1", 64'(valid_g1), 64'd1);
    checkOutput("diff_g1", diff_g1, d);
    checkOutput("borrow_g1", 64'(borrow_g1), 64'(e_borrow));
    checkOutput("zero_g1", 64'(zero_g1), 64'(e_zero));
    checkOutput("lt_g1", 64'(lt_g1), 64'(e_lt));
    checkOutput("ovf_g1", 64'(ovf_g1), 64'(e_ovf));
    a32 = a[31:0];
    b32 = b[31:0];
    d32 = a32 - b32;
    checkOutput("valid_32", 64'(valid_32), 64'd1);
    checkOutput("diff_32", 64'(diff_32), 64'(d32));
    checkOutput("borrow_32", 64'(borrow_32), 64'(a32 < b32));
    checkOutput("zero_32", 64'(zero_32), 64'(d32 == 32'd0));
    checkOutput("lt_32", 64'(lt_32), 64'($signed(a32) < $signed(b32)));
    checkOutput("ovf_32", 64'(ovf_32), 64'((a32[31] != b32[31]) && (d32[31] != a32[31])));
  endtask

  // Drives one cycle from a negedge, samples #1 later, returns at the next negedge.
  task automatic applyStimulus(input logic v, input logic [63:0] a, input logic [63:0] b,
                               input logic ordy, output logic acc);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) compareResult();
    acc = in_valid && in_ready;
    if (acc) begin
      sb.push_back({a, b});
      checkOutput("ready_g1", 64'(rdy_g1), 64'd1);
      checkOutput("ready_32", 64'(rdy_32), 64'd1);
    end
    @(negedge clk);
  endtask

  task automatic drainAll(input int budget);
    logic acc;
    int   n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      applyStimulus(1'b0, '0, '0, 1'b1, acc);
      n++;
    end
    checkOutput("drain_done", 64'(sb.size()), 64'd0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, '0, '0, 1'b1, acc);
  endtask

  initial begin
    logic        acc;
    logic [63:0] ra, rb;
    logic [63:0] bpa[5];
    logic [63:0] bpb[5];
    logic [63:0] dira[3];
    logic [63:0] dirb[3];
    int          sent, cyc, pops0;

    @(negedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_diff", out_diff, 64'd0);
    checkOutput("rst_flags", 64'({out_borrow, out_zero, out_lt, out_ovf}), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // single op latency
    applyStimulus(1'b1, 64'h5, 64'h3, 1'b1, acc);
    checkOutput("lat_accept", 64'(acc), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      checkOutput($sformatf("lat_valid_%0d", k), 64'(out_valid), 64'(k == 3));
      if (out_valid) begin
        checkOutput("lat_diff", out_diff, 64'd2);
        checkOutput("lat_flags", 64'({out_borrow, out_zero, out_lt, out_ovf}), 64'd0);
        compareResult();
      end
      @(negedge clk);
    end

    dira[0] = 64'h0;                   dirb[0] = 64'h1;
    dira[1] = 64'h8000_0000_0000_0000; dirb[1] = 64'h1;
    dira[2] = 64'hDEAD_BEEF_0123_4567; dirb[2] = 64'hDEAD_BEEF_0123_4567;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, dira[k], dirb[k], 1'b1, acc);
      checkOutput($sformatf("dir_accept_%0d", k), 64'(acc), 64'd1);
    end
    drainAll(20);

    // backpressure: capacity 3, held head result, ordered release
    for (int k = 0; k < 5; k++) begin
      bpa[k] = {$urandom, $urandom};
      bpb[k] = {$urandom, $urandom};
    end
    pops0 = pops;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, bpa[k < 3 ? k : 3], bpb[k < 3 ? k : 3], 1'b0, acc);
      checkOutput($sformatf("bp_accept_%0d", k), 64'(acc), 64'(k < 3));
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, bpa[3], bpb[3], 1'b0, acc);
      checkOutput("bp_stall_ready", 64'(acc), 64'd0);
      checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_hold_diff", out_diff, bpa[0] - bpb[0]);
    end
    for (int k = 3; k < 5; k++) begin
      cyc = 0;
      acc = 1'b0;
      while (!acc && cyc < 10) begin
        applyStimulus(1'b1, bpa[k], bpb[k], 1'b1, acc);
        cyc++;
      end
      checkOutput($sformatf("bp_late_accept_%0d", k), 64'(acc), 64'd1);
    end
    drainAll(20);
    checkOutput("bp_result_count", 64'(pops - pops0), 64'd5);

    // reset with three operations in flight
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, acc);
    end
    rst = 1'b1;
    applyStimulus(1'b1, 64'h77, 64'h11, 1'b0, acc);
    checkOutput("rst_cycle_accept", 64'(acc), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_out_diff", out_diff, 64'd0);
    checkOutput("midrst_flags", 64'({out_borrow, out_zero, out_lt, out_ovf}), 64'd0);
    sb.delete();
    @(negedge clk);
    applyStimulus(1'b1, 64'h1234, 64'h1235, 1'b1, acc);
    checkOutput("post_rst_accept", 64'(acc), 64'd1);
    drainAll(20);

    // random traffic with edge-biased operands
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: ra = 64'h8000_0000_0000_0000;
        2: rb = 64'hFFFF_FFFF_FFFF_FFFF;
        3: ra = 64'h0;
        default: ;
      endcase
      applyStimulus($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 3) != 0, acc);
      if (acc) sent++;
      cyc++;
    end
    checkOutput("rand_sent", 64'(sent), 64'd10000);
    drainAll(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
